// File: rtl/clock_timekeeper.sv
// clock_timekeeper: time-of-day counter, alarm time and alarm state machine
// for the VGA clock. Every output is registered.
// Build option: define SNOOZE_EN to add the SNOOZE state. In that build an
// al_adj pulse while ringing snoozes the alarm instead of moving the alarm time.
// Handshake note: all inputs are single-cycle pulses with no back-pressure;
// a pulse is consumed in the cycle it is high. There is no valid/ready pair.
module clock_timekeeper #(
  parameter int AL_MIN_STEP    = 10,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hr_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  input  logic       tone,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [3:0] al_hours,
  output logic [5:0] al_minutes,
  output logic       al_on,
  output logic       alarm_active,
  output logic       buzzer,
  output logic [1:0] dbg_state
);

  localparam int CNT_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RING_LOAD = CW'(RING_SECONDS);
`ifdef SNOOZE_EN
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SECONDS);
`endif
  localparam logic [5:0] AL_STEP = 6'(AL_MIN_STEP);
  localparam logic [5:0] AL_LAST = 6'(60 - AL_MIN_STEP);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARMED   = 2'd1,
`ifdef SNOOZE_EN
    ST_SNOOZE  = 2'd3,
`endif
    ST_RINGING = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [3:0]    r_hours, w_hr_next, r_al_hours, w_al_hr_next;
  logic [5:0]    r_minutes, w_min_next, r_seconds, w_sec_next, r_al_minutes, w_al_min_next;
  logic          r_al_on, r_alarm_active, r_buzzer;
  logic          w_sec_inc, w_sec_carry, w_min_inc, w_min_carry, w_hr_inc;
  logic          w_al_adj_en, w_match, w_timeout;

  // Next time-of-day: a tick carry and an adjust pulse on the same field count once.
  always_comb begin
    w_sec_inc   = tick_1hz | sec_adj;
    w_sec_carry = tick_1hz & (r_seconds == 6'd59);
    w_min_inc   = min_adj | w_sec_carry;
    w_min_carry = w_sec_carry & (r_minutes == 6'd59);
    w_hr_inc    = hr_adj | w_min_carry;
    w_sec_next  = r_seconds;
    w_min_next  = r_minutes;
    w_hr_next   = r_hours;
    if (w_sec_inc) w_sec_next = (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
    if (w_min_inc) w_min_next = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
    if (w_hr_inc)  w_hr_next  = (r_hours == 4'd11)   ? 4'd0 : r_hours + 4'd1;
  end

  // Next alarm time: al_adj steps minutes, carrying into hours.
  always_comb begin
`ifdef SNOOZE_EN
    // While ringing or snoozed the pulse belongs to the snooze function.
    w_al_adj_en = al_adj & ((r_state == ST_OFF) | (r_state == ST_ARMED));
`else
    w_al_adj_en = al_adj;
`endif
    w_al_min_next = r_al_minutes;
    w_al_hr_next  = r_al_hours;
    if (w_al_adj_en) begin
      if (r_al_minutes == AL_LAST) begin
        w_al_min_next = 6'd0;
        w_al_hr_next  = (r_al_hours == 4'd11) ? 4'd0 : r_al_hours + 4'd1;
      end else begin
        w_al_min_next = r_al_minutes + AL_STEP;
      end
    end
  end

  // Alarm FSM next state; priority is al_toggle, then match/timeout, then al_adj.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_match      = (w_sec_next == 6'd0) && (w_min_next == w_al_min_next) &&
                   (w_hr_next == w_al_hr_next);
    w_timeout    = tick_1hz && (r_cnt <= CW'(1));
    case (r_state)
      ST_OFF: begin
        if (al_toggle) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (al_toggle) begin
          w_state_next = ST_OFF;
        end else if (w_match) begin
          w_state_next = ST_RINGING;
          w_cnt_next   = RING_LOAD;
        end
      end
      ST_RINGING: begin
        if (al_toggle) begin
          w_state_next = ST_OFF;
          w_cnt_next   = '0;
        end else if (w_timeout) begin
          w_state_next = ST_ARMED;
          w_cnt_next   = '0;
`ifdef SNOOZE_EN
        end else if (al_adj) begin
          w_state_next = ST_SNOOZE;
          w_cnt_next   = SNOOZE_LOAD;
`endif
        end else if (tick_1hz) begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`ifdef SNOOZE_EN
      ST_SNOOZE: begin
        if (al_toggle) begin
          w_state_next = ST_OFF;
          w_cnt_next   = '0;
        end else if (w_timeout) begin
          w_state_next = ST_RINGING;
          w_cnt_next   = RING_LOAD;
        end else if (tick_1hz) begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`endif
      default: begin
        w_state_next = ST_OFF;
        w_cnt_next   = '0;
      end
    endcase
  end

  // FSM state and ring/snooze counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Time and alarm-time registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hours      <= '0;
      r_minutes    <= '0;
      r_seconds    <= '0;
      r_al_hours   <= '0;
      r_al_minutes <= '0;
    end else begin
      r_hours      <= w_hr_next;
      r_minutes    <= w_min_next;
      r_seconds    <= w_sec_next;
      r_al_hours   <= w_al_hr_next;
      r_al_minutes <= w_al_min_next;
    end
  end

  // Status flags and gated buzzer, registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_al_on        <= 1'b0;
      r_alarm_active <= 1'b0;
      r_buzzer       <= 1'b0;
    end else begin
      r_al_on        <= (w_state_next != ST_OFF);
      r_alarm_active <= (w_state_next == ST_RINGING);
      r_buzzer       <= (w_state_next == ST_RINGING) & tone & ~w_sec_next[0];
    end
  end

  assign hours        = r_hours;
  assign minutes      = r_minutes;
  assign seconds      = r_seconds;
  assign al_hours     = r_al_hours;
  assign al_minutes   = r_al_minutes;
  assign al_on        = r_al_on;
  assign alarm_active = r_alarm_active;
  assign buzzer       = r_buzzer;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed, table-driven bench for clock_timekeeper.
// Each row drives an input pattern for a number of cycles, then compares the
// full output set against a hand-computed expectation.
module tb_clock_timekeeper;

  logic       clk, reset;
  logic       tick_1hz, sec_adj, min_adj, hr_adj, al_adj, al_toggle, tone;
  logic [3:0] hours, al_hours;
  logic [5:0] minutes, seconds, al_minutes;
  logic       al_on, alarm_active, buzzer;
  logic [1:0] dbg_state;

  clock_timekeeper dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sec_adj(sec_adj),
    .min_adj(min_adj), .hr_adj(hr_adj), .al_adj(al_adj), .al_toggle(al_toggle),
    .tone(tone), .hours(hours), .minutes(minutes), .seconds(seconds),
    .al_hours(al_hours), .al_minutes(al_minutes), .al_on(al_on),
    .alarm_active(alarm_active), .buzzer(buzzer), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] I_TICK = 7'b1000000;
  localparam logic [6:0] I_SEC  = 7'b0100000;
  localparam logic [6:0] I_MIN  = 7'b0010000;
  localparam logic [6:0] I_HR   = 7'b0001000;
  localparam logic [6:0] I_AL   = 7'b0000100;
  localparam logic [6:0] I_TOG  = 7'b0000010;
  localparam logic [6:0] I_TONE = 7'b0000001;
  localparam logic [6:0] I_NONE = 7'b0000000;

  typedef struct {
    string       name;
    int          reps;
    logic [6:0]  in;
    logic [28:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [28:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          split_idx;

  function automatic vec_t mk(input string n, input int reps, input logic [6:0] in,
                              input int h, input int m, input int s,
                              input int ah, input int am,
                              input logic on, input logic act, input logic buz);
    vec_t v;
    v.name = n;
    v.reps = reps;
    v.in   = in;
    v.exp  = {4'(h), 6'(m), 6'(s), 4'(ah), 6'(am), on, act, buz};
    return v;
  endfunction

  function automatic logic [28:0] snap();
    return {hours, minutes, seconds, al_hours, al_minutes, al_on, alarm_active, buzzer};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [28:0] got);
    logic [28:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d al %0d:%0d on=%b act=%b buz=%b, want %0d:%0d:%0d al %0d:%0d on=%b act=%b buz=%b",
               name, got[28:25], got[24:19], got[18:13], got[12:9], got[8:3], got[2], got[1], got[0],
               e[28:25], e[24:19], e[18:13], e[12:9], e[8:3], e[2], e[1], e[0]);
    end
  endtask

  // driver
  task automatic drive(input logic [6:0] in);
    {tick_1hz, sec_adj, min_adj, hr_adj, al_adj, al_toggle, tone} = in;
  endtask

  task automatic apply(input vec_t v);
    drive(v.in);
    repeat (v.reps) @(negedge clk);
    drive(I_NONE);
    exp_q.push_back(v.exp);
    check(v.name, snap());
  endtask

  initial begin
    // part A: time-of-day, adjust corners, alarm ring, toggle priority
    vecs.push_back(mk("tick_3661",       3661, I_TICK,               1, 1, 1,  0, 0,  0, 0, 0));
    vecs.push_back(mk("hr_adj_10",         10, I_HR,                11, 1, 1,  0, 0,  0, 0, 0));
    vecs.push_back(mk("min_adj_58",        58, I_MIN,               11,59, 1,  0, 0,  0, 0, 0));
    vecs.push_back(mk("sec_adj_58",        58, I_SEC,               11,59,59,  0, 0,  0, 0, 0));
    vecs.push_back(mk("full_ripple",        1, I_TICK,               0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("hr_adj_wrap",       12, I_HR,                 0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("sec_to_59",         59, I_SEC,                0, 0,59,  0, 0,  0, 0, 0));
    vecs.push_back(mk("tick_and_sec_adj",   1, I_TICK|I_SEC,         0, 1, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("sec_to_59b",        59, I_SEC,                0, 1,59,  0, 0,  0, 0, 0));
    vecs.push_back(mk("sec_adj_no_carry",   1, I_SEC,                0, 1, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("min_to_59",         58, I_MIN,                0,59, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("min_adj_no_carry",   1, I_MIN,                0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("sec_to_59c",        59, I_SEC,                0, 0,59,  0, 0,  0, 0, 0));
    vecs.push_back(mk("carry_plus_min_adj", 1, I_TICK|I_MIN,         0, 1, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("min_to_59b",        58, I_MIN,                0,59, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("sec_to_59d",        59, I_SEC,                0,59,59,  0, 0,  0, 0, 0));
    vecs.push_back(mk("carry_plus_adjs",    1, I_TICK|I_MIN|I_HR,    1, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("hr_back_to_0",      11, I_HR,                 0, 0, 0,  0, 0,  0, 0, 0));
    vecs.push_back(mk("al_adj_5",           5, I_AL,                 0, 0, 0,  0,50,  0, 0, 0));
    vecs.push_back(mk("al_adj_wrap",        1, I_AL,                 0, 0, 0,  1, 0,  0, 0, 0));
    vecs.push_back(mk("arm",                1, I_TOG,                0, 0, 0,  1, 0,  1, 0, 0));
    vecs.push_back(mk("run_to_0_59_59",  3599, I_TICK|I_TONE,        0,59,59,  1, 0,  1, 0, 0));
    vecs.push_back(mk("ring_start",         1, I_TICK|I_TONE,        1, 0, 0,  1, 0,  1, 1, 1));
    vecs.push_back(mk("ring_tone_even",     3, I_TONE,               1, 0, 0,  1, 0,  1, 1, 1));
    vecs.push_back(mk("ring_odd_sec",       1, I_TICK|I_TONE,        1, 0, 1,  1, 0,  1, 1, 0));
    vecs.push_back(mk("ring_tone_low",      1, I_TICK,               1, 0, 2,  1, 0,  1, 1, 0));
    vecs.push_back(mk("ring_tone_back",     1, I_TONE,               1, 0, 2,  1, 0,  1, 1, 1));
    vecs.push_back(mk("ring_59_ticks",     57, I_TICK,               1, 0,59,  1, 0,  1, 1, 0));
    vecs.push_back(mk("ring_timeout",       1, I_TICK|I_TONE,        1, 1, 0,  1, 0,  1, 0, 0));
    vecs.push_back(mk("button_match",      59, I_MIN|I_TONE,         1, 0, 0,  1, 0,  1, 1, 1));
    vecs.push_back(mk("ring_tick",          1, I_TICK|I_TONE,        1, 0, 1,  1, 0,  1, 1, 0));
    vecs.push_back(mk("ring_toggle_tick",   1, I_TICK|I_TOG|I_TONE,  1, 0, 2,  1, 0,  0, 0, 0));
    vecs.push_back(mk("rearm",              1, I_TOG,                1, 0, 2,  1, 0,  1, 0, 0));
    vecs.push_back(mk("hr_to_0",           11, I_HR,                 0, 0, 2,  1, 0,  1, 0, 0));
    vecs.push_back(mk("min_to_59c",        59, I_MIN,                0,59, 2,  1, 0,  1, 0, 0));
    vecs.push_back(mk("sec_to_59e",        57, I_SEC,                0,59,59,  1, 0,  1, 0, 0));
    vecs.push_back(mk("toggle_beats_match", 1, I_TICK|I_TOG,         1, 0, 0,  1, 0,  0, 0, 0));
    vecs.push_back(mk("rearm_at_match",     1, I_TOG,                1, 0, 0,  1, 0,  1, 0, 0));
    vecs.push_back(mk("hr_wrap_match",     12, I_HR|I_TONE,          1, 0, 0,  1, 0,  1, 1, 1));
    split_idx = vecs.size();
    // part B: after a reset, snooze behaviour (build dependent)
    vecs.push_back(mk("b_al_adj",           1, I_AL,                 0, 0, 0,  0,10,  0, 0, 0));
    vecs.push_back(mk("b_arm",              1, I_TOG,                0, 0, 0,  0,10,  1, 0, 0));
    vecs.push_back(mk("b_ring",            10, I_MIN,                0,10, 0,  0,10,  1, 1, 0));
`ifdef SNOOZE_EN
    vecs.push_back(mk("b_snooze",           1, I_AL,                 0,10, 0,  0,10,  1, 0, 0));
    vecs.push_back(mk("b_snooze_ignore",    1, I_AL,                 0,10, 0,  0,10,  1, 0, 0));
    vecs.push_back(mk("b_snooze_299",     299, I_TICK,               0,14,59,  0,10,  1, 0, 0));
    vecs.push_back(mk("b_snooze_end",       1, I_TICK,               0,15, 0,  0,10,  1, 1, 0));
`else
    vecs.push_back(mk("b_al_adj_ringing",   1, I_AL,                 0,10, 0,  0,20,  1, 1, 0));
    vecs.push_back(mk("b_al_adj_again",     1, I_AL,                 0,10, 0,  0,30,  1, 1, 0));
    vecs.push_back(mk("b_ticks_299",      299, I_TICK,               0,14,59,  0,30,  1, 0, 0));
    vecs.push_back(mk("b_ticks_300",        1, I_TICK,               0,15, 0,  0,30,  1, 0, 0));
`endif

    // reset sequence
    reset = 1'b1;
    drive(I_NONE);
    repeat (3) @(negedge clk);
    exp_q.push_back('0);
    check("reset_outputs", snap());
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    reset = 1'b0;

    for (int i = 0; i < split_idx; i++) apply(vecs[i]);

    // reset while ringing clears everything on the next edge
    reset = 1'b1;
    tone  = 1'b1;
    @(negedge clk);
    exp_q.push_back('0);
    check("reset_mid_ring", snap());
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_ring_state: got %0d want 0", dbg_state);
    end
    reset = 1'b0;
    tone  = 1'b0;

    for (int i = split_idx; i < vecs.size(); i++) apply(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
